// File: rtl/nand_async_seq.sv
`timescale 1ns/1ps
// nand_async_seq: turns a byte-wide request stream into ONFI asynchronous-mode
// latch cycles (command, address, data-in, data-out) for the NAND PHY.
// Every timing phase is counted in clk0 cycles.
//
// Ports:
//   clk0, rst0           clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_type/req_data    00 CMD, 01 ADDR, 10 DIN, 11 DOUT; byte payload
//   req_ce/req_last      active-high chip select; release CE# after this request
//   cfg_wpn              write-protect level forwarded to ctrl_wpn
//   rsp_valid/rsp_data   one-cycle pulse with the captured read byte
//   ctrl_*               CLE, ALE, RE# (wrn), WP#, CE#, WE# (wen), wen_sel to PHY
//   dq_oe_n              active-low DQ output enable
//   wr_data_rise/fall    write byte to PHY (both halves carry the same byte)
//   rd_data_comb         PHY combinational read data
module nand_async_seq #(
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_WP    = 3,
    parameter int unsigned T_WH    = 2,
    parameter int unsigned T_RP    = 3,
    parameter int unsigned T_REH   = 2
) (
    input  logic       clk0,
    input  logic       rst0,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_type,
    input  logic [7:0] req_data,
    input  logic [1:0] req_ce,
    input  logic       req_last,
    input  logic       cfg_wpn,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       ctrl_cle,
    output logic       ctrl_ale,
    output logic       ctrl_wrn,
    output logic       ctrl_wpn,
    output logic [1:0] ctrl_cen,
    output logic       ctrl_wen,
    output logic       ctrl_wen_sel,
    output logic       dq_oe_n,
    output logic [7:0] wr_data_rise,
    output logic [7:0] wr_data_fall,
    input  logic [7:0] rd_data_comb
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CE_W   = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TYPE_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [TYPE_W-1:0] TYPE_CMD  = 2'b00;
    localparam logic [TYPE_W-1:0] TYPE_ADDR = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_DOUT = 2'b11;

    // Counter reload values: each phase lasts (load + 1) cycles.
    localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] CNT_WP    = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] CNT_WH    = CNT_W'(T_WH - 1);
    localparam logic [CNT_W-1:0] CNT_RP    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] CNT_REH   = CNT_W'(T_REH - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [TYPE_W-1:0] r_type;
    logic              r_last;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_cle;
    logic              r_ale;
    logic              r_wrn;
    logic              r_wpn;
    logic [CE_W-1:0]   r_cen;
    logic              r_wen;
    logic              r_wen_sel;
    logic              r_dq_oe_n;
    logic [DATA_W-1:0] r_wr_data;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [TYPE_W-1:0] w_type_nxt;
    logic              w_last_nxt;
    logic              w_ready_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_data_nxt;
    logic              w_cle_nxt;
    logic              w_ale_nxt;
    logic              w_wrn_nxt;
    logic [CE_W-1:0]   w_cen_nxt;
    logic              w_wen_nxt;
    logic              w_dq_oe_n_nxt;
    logic [DATA_W-1:0] w_wr_data_nxt;
    logic              w_is_rd;
    logic              w_cnt_zero;

    assign w_is_rd    = (r_type == TYPE_DOUT);
    assign w_cnt_zero = (r_cnt == '0);

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_type_nxt      = r_type;
        w_last_nxt      = r_last;
        w_ready_nxt     = r_req_ready;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_cle_nxt       = r_cle;
        w_ale_nxt       = r_ale;
        w_wrn_nxt       = r_wrn;
        w_cen_nxt       = r_cen;
        w_wen_nxt       = r_wen;
        w_dq_oe_n_nxt   = r_dq_oe_n;
        w_wr_data_nxt   = r_wr_data;

        case (r_state)
            ST_IDLE: begin
                w_cle_nxt     = 1'b0;
                w_ale_nxt     = 1'b0;
                w_dq_oe_n_nxt = 1'b1;
                w_wen_nxt     = 1'b1;
                w_wrn_nxt     = 1'b1;
                w_ready_nxt   = 1'b1;
                if (req_valid) begin
                    // Latch controls now so they are stable for the setup phase.
                    w_state_nxt   = ST_SETUP;
                    w_cnt_nxt     = CNT_SETUP;
                    w_type_nxt    = req_type;
                    w_last_nxt    = req_last;
                    w_ready_nxt   = 1'b0;
                    w_cen_nxt     = ~req_ce;
                    w_cle_nxt     = (req_type == TYPE_CMD);
                    w_ale_nxt     = (req_type == TYPE_ADDR);
                    w_dq_oe_n_nxt = (req_type == TYPE_DOUT);
                    if (req_type != TYPE_DOUT) begin
                        w_wr_data_nxt = req_data;
                    end
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_PULSE;
                    if (w_is_rd) begin
                        w_cnt_nxt = CNT_RP;
                        w_wrn_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = CNT_WP;
                        w_wen_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (w_cnt_zero) begin
                    // Read data is sampled on the RE# rising edge.
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = w_is_rd ? CNT_REH : CNT_WH;
                    w_wen_nxt   = 1'b1;
                    w_wrn_nxt   = 1'b1;
                    if (w_is_rd) begin
                        w_rsp_data_nxt  = rd_data_comb;
                        w_rsp_valid_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt   = ST_IDLE;
                    w_ready_nxt   = 1'b1;
                    w_cle_nxt     = 1'b0;
                    w_ale_nxt     = 1'b0;
                    w_dq_oe_n_nxt = 1'b1;
                    if (r_last) begin
                        w_cen_nxt = {CE_W{1'b1}};
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_type      <= '0;
            r_last      <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_cle       <= 1'b0;
            r_ale       <= 1'b0;
            r_wrn       <= 1'b1;
            r_wpn       <= 1'b0;
            r_cen       <= {CE_W{1'b1}};
            r_wen       <= 1'b1;
            r_wen_sel   <= 1'b1;
            r_dq_oe_n   <= 1'b1;
            r_wr_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_type      <= w_type_nxt;
            r_last      <= w_last_nxt;
            r_req_ready <= w_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_cle       <= w_cle_nxt;
            r_ale       <= w_ale_nxt;
            r_wrn       <= w_wrn_nxt;
            r_wpn       <= cfg_wpn;
            r_cen       <= w_cen_nxt;
            r_wen       <= w_wen_nxt;
            r_wen_sel   <= 1'b1;
            r_dq_oe_n   <= w_dq_oe_n_nxt;
            r_wr_data   <= w_wr_data_nxt;
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign ctrl_cle     = r_cle;
    assign ctrl_ale     = r_ale;
    assign ctrl_wrn     = r_wrn;
    assign ctrl_wpn     = r_wpn;
    assign ctrl_cen     = r_cen;
    assign ctrl_wen     = r_wen;
    assign ctrl_wen_sel = r_wen_sel;
    assign dq_oe_n      = r_dq_oe_n;
    assign wr_data_rise = r_wr_data;
    assign wr_data_fall = r_wr_data;

endmodule

// File: tb/tb_nand_async_seq.sv
`timescale 1ns/1ps
// Bench for nand_async_seq: default-timing instance plus a fast-timing instance.
module tb_nand_async_seq;

    localparam int TS = 1;
    localparam int TP_W = 3;
    localparam int TH_W = 2;
    localparam int TP_R = 3;
    localparam int TH_R = 2;
    localparam logic [1:0] CMD = 2'b00;
    localparam logic [1:0] ADDR = 2'b01;
    localparam logic [1:0] DIN = 2'b10;
    localparam logic [1:0] DOUT = 2'b11;
    // {ready, rsp_valid, cle, ale, wrn, wen, wen_sel, dq_oe_n, cen[1:0], wpn}
    localparam logic [10:0] RST_CTRL = 11'b1_0_0_0_1_1_1_1_11_0;

    logic       clk0 = 1'b0;
    logic       rst0;
    logic       req_valid, f_req_valid;
    logic [1:0] req_type;
    logic [7:0] req_data;
    logic [1:0] req_ce;
    logic       req_last;
    logic       cfg_wpn;
    logic [7:0] rd_data_comb;

    logic       req_ready, rsp_valid, ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wpn;
    logic       ctrl_wen, ctrl_wen_sel, dq_oe_n;
    logic [1:0] ctrl_cen;
    logic [7:0] rsp_data, wr_data_rise, wr_data_fall;

    logic       f_req_ready, f_rsp_valid, f_cle, f_ale, f_wrn, f_wpn;
    logic       f_wen, f_wen_sel, f_dq_oe_n;
    logic [1:0] f_cen;
    logic [7:0] f_rsp_data, f_wr_rise, f_wr_fall;

    logic [10:0] obs_ctrl, f_obs_ctrl;
    logic [23:0] obs_data, f_obs_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_cen;
    logic [7:0] exp_wr;
    logic [7:0] exp_rsp;

    always #5 clk0 = ~clk0;

    nand_async_seq u_dut (
        .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_data(req_data), .req_ce(req_ce), .req_last(req_last),
        .cfg_wpn(cfg_wpn), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ctrl_cle(ctrl_cle), .ctrl_ale(ctrl_ale), .ctrl_wrn(ctrl_wrn), .ctrl_wpn(ctrl_wpn),
        .ctrl_cen(ctrl_cen), .ctrl_wen(ctrl_wen), .ctrl_wen_sel(ctrl_wen_sel),
        .dq_oe_n(dq_oe_n), .wr_data_rise(wr_data_rise), .wr_data_fall(wr_data_fall),
        .rd_data_comb(rd_data_comb)
    );

    nand_async_seq #(.T_SETUP(1), .T_WP(1), .T_WH(1), .T_RP(1), .T_REH(1)) u_dut_fast (
        .clk0(clk0), .rst0(rst0), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_type(req_type), .req_data(req_data), .req_ce(req_ce), .req_last(req_last),
        .cfg_wpn(cfg_wpn), .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data),
        .ctrl_cle(f_cle), .ctrl_ale(f_ale), .ctrl_wrn(f_wrn), .ctrl_wpn(f_wpn),
        .ctrl_cen(f_cen), .ctrl_wen(f_wen), .ctrl_wen_sel(f_wen_sel),
        .dq_oe_n(f_dq_oe_n), .wr_data_rise(f_wr_rise), .wr_data_fall(f_wr_fall),
        .rd_data_comb(rd_data_comb)
    );

    assign obs_ctrl   = {req_ready, rsp_valid, ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wen,
                         ctrl_wen_sel, dq_oe_n, ctrl_cen, ctrl_wpn};
    assign obs_data   = {rsp_data, wr_data_rise, wr_data_fall};
    assign f_obs_ctrl = {f_req_ready, f_rsp_valid, f_cle, f_ale, f_wrn, f_wen,
                         f_wen_sel, f_dq_oe_n, f_cen, f_wpn};
    assign f_obs_data = {f_rsp_data, f_wr_rise, f_wr_fall};

    // Timeline model: cycle k after the accept edge (k=0 is idle/accept cycle).
    // Busy for ts+tp+th cycles; strobe low during cycles ts+1..ts+tp.
    function automatic logic [10:0] model_ctrl(input logic [1:0] typ, input int k,
                                               input int ts, input int tp, input int th,
                                               input logic [1:0] cen, input logic wpn);
        int   total;
        logic busy, rd, pulse;
        total = ts + tp + th;
        busy  = (k >= 1) && (k <= total);
        rd    = (typ == DOUT);
        pulse = (k > ts) && (k <= ts + tp);
        return {!busy, rd && (k == ts + tp + 1), busy && (typ == CMD), busy && (typ == ADDR),
                !(rd && pulse), !(!rd && pulse), 1'b1, !busy || rd, cen, wpn};
    endfunction

    // One request on the default instance, starting at a negedge of an idle cycle.
    task automatic run_req(input logic [1:0] typ, input logic [7:0] data, input logic [1:0] ce,
                           input logic last, input logic [7:0] rd, input bit garbage);
        int tp, th, total;
        logic [10:0] exp_ctrl;
        tp = (typ == DOUT) ? TP_R : TP_W;
        th = (typ == DOUT) ? TH_R : TH_W;
        total = TS + tp + th;
        req_valid = 1'b1; req_type = typ; req_data = data; req_ce = ce; req_last = last;
        rd_data_comb = 8'($urandom);
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk0);
            if (k == 1) begin
                exp_cen = ~ce;
                if (typ != DOUT) exp_wr = data;
            end
            if (k == total + 1 && last) exp_cen = 2'b11;
            if (typ == DOUT && k == TS + tp + 1) exp_rsp = rd;
            exp_ctrl = model_ctrl(typ, k, TS, tp, th, exp_cen, cfg_wpn);
            n_checks++;
            if (obs_ctrl !== exp_ctrl) begin
                n_errors++;
                $display("FAIL ctrl type=%0d k=%0d: got %b expected %b", typ, k, obs_ctrl, exp_ctrl);
            end
            n_checks++;
            if (obs_data !== {exp_rsp, exp_wr, exp_wr}) begin
                n_errors++;
                $display("FAIL data type=%0d k=%0d: got %h expected %h", typ, k, obs_data,
                         {exp_rsp, exp_wr, exp_wr});
            end
            if (garbage && k < total) begin
                req_valid = 1'($urandom);
                req_type = 2'($urandom); req_data = 8'($urandom);
                req_ce = 2'($urandom); req_last = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            rd_data_comb = (k == TS + tp) ? rd : 8'($urandom);
            cfg_wpn = 1'($urandom);
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b1; cfg_wpn = 1'b1; req_valid = 1'b0; f_req_valid = 1'b0;
        req_type = CMD; req_data = 8'h00; req_ce = 2'b00; req_last = 1'b0; rd_data_comb = 8'h00;
        repeat (2) @(negedge clk0);
        n_checks++;
        if (obs_ctrl !== RST_CTRL || obs_data !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_main: got %b/%h expected %b/%h", obs_ctrl, obs_data, RST_CTRL, 24'h0);
        end
        n_checks++;
        if (f_obs_ctrl !== RST_CTRL || f_obs_data !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_fast: got %b/%h expected %b/%h", f_obs_ctrl, f_obs_data, RST_CTRL, 24'h0);
        end
        rst0 = 1'b0;
        @(negedge clk0);
        n_checks++;
        if (obs_ctrl !== {RST_CTRL[10:1], 1'b1}) begin
            n_errors++;
            $display("FAIL reset_release_wpn: got %b expected %b", obs_ctrl, {RST_CTRL[10:1], 1'b1});
        end
        exp_cen = 2'b11; exp_wr = 8'h00; exp_rsp = 8'h00;
    endtask

    task automatic test_cmd;
        run_req(CMD, 8'h00, 2'b01, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        int a0, a1, n_acc;
        a0 = -1; a1 = -1; n_acc = 0;
        req_valid = 1'b1; req_type = ADDR; req_data = 8'h11; req_ce = 2'b01; req_last = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk0);
            n_checks++;
            if (ctrl_cle !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_cle c=%0d: got %b expected 0", c, ctrl_cle);
            end
            if ((n_acc == 1 && c <= a0 + 6) || (n_acc == 2 && c <= a1 + 6)) begin
                n_checks++;
                if ({ctrl_ale, wr_data_rise, wr_data_fall} !==
                    {1'b1, (n_acc == 1) ? 8'h11 : 8'h22, (n_acc == 1) ? 8'h11 : 8'h22}) begin
                    n_errors++;
                    $display("FAIL b2b_ale_data c=%0d: got %b %h %h expected ale=1 byte %h", c,
                             ctrl_ale, wr_data_rise, wr_data_fall, (n_acc == 1) ? 8'h11 : 8'h22);
                end
            end
            if (req_valid && req_ready) begin
                if (n_acc == 0) a0 = c; else a1 = c;
                n_acc++;
            end
            if (n_acc == 1 && c > a0) req_data = 8'h22;
            if (n_acc == 2 && c > a1) req_valid = 1'b0;
        end
        n_checks++;
        if (a0 < 0 || a1 - a0 != 7) begin
            n_errors++;
            $display("FAIL b2b_spacing: got %0d expected 7", a1 - a0);
        end
        exp_cen = 2'b10; exp_wr = 8'h22;
    endtask

    task automatic test_dout;
        run_req(DOUT, 8'h00, 2'b01, 1'b1, 8'hA5, 1'b0);
    endtask

    task automatic test_ce_change;
        run_req(DIN, 8'hC3, 2'b10, 1'b0, 8'h00, 1'b0);
        run_req(CMD, 8'h70, 2'b00, 1'b0, 8'h00, 1'b0);
        run_req(DOUT, 8'h00, 2'b11, 1'b1, 8'h3C, 1'b1);
    endtask

    task automatic test_reset_mid_op;
        logic [1:0] typ;
        for (int t = 0; t < 2; t++) begin
            typ = (t == 0) ? DIN : DOUT;
            req_valid = 1'b1; req_type = typ; req_data = 8'h5A; req_ce = 2'b01; req_last = 1'b0;
            for (int k = 1; k <= TS + 3; k++) begin
                @(negedge clk0);
                req_valid = 1'b0;
            end
            n_checks++;
            if ((typ == DOUT ? ctrl_wrn : ctrl_wen) !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_pulse type=%0d: got 1 expected 0", typ);
            end
            rst0 = 1'b1; rd_data_comb = 8'hEE;
            @(negedge clk0);
            n_checks++;
            if (obs_ctrl !== RST_CTRL || obs_data !== 24'h0) begin
                n_errors++;
                $display("FAIL midrst_values type=%0d: got %b/%h expected %b/%h", typ,
                         obs_ctrl, obs_data, RST_CTRL, 24'h0);
            end
            rst0 = 1'b0;
            exp_cen = 2'b11; exp_wr = 8'h00; exp_rsp = 8'h00;
            @(negedge clk0);
            n_checks++;
            if ({rsp_valid, req_ready, ctrl_wpn} !== {1'b0, 1'b1, cfg_wpn}) begin
                n_errors++;
                $display("FAIL midrst_after type=%0d: got %b expected %b", typ,
                         {rsp_valid, req_ready, ctrl_wpn}, {1'b0, 1'b1, cfg_wpn});
            end
        end
        run_req(DIN, 8'h96, 2'b01, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_fast_params;
        logic [10:0] exp_ctrl;
        logic [1:0]  f_cen_exp;
        f_req_valid = 1'b1; req_type = CMD; req_data = 8'h3C; req_ce = 2'b10; req_last = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk0);
            f_req_valid = 1'b0;
            f_cen_exp = (k == 4) ? 2'b11 : 2'b01;
            exp_ctrl = model_ctrl(CMD, k, 1, 1, 1, f_cen_exp, cfg_wpn);
            n_checks++;
            if (f_obs_ctrl !== exp_ctrl || f_obs_data !== {8'h00, 8'h3C, 8'h3C}) begin
                n_errors++;
                $display("FAIL fast_cmd k=%0d: got %b/%h expected %b/%h", k, f_obs_ctrl,
                         f_obs_data, exp_ctrl, {8'h00, 8'h3C, 8'h3C});
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            run_req(2'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_back_to_back();
        test_dout();
        test_ce_change();
        test_reset_mid_op();
        test_fast_params();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
